// File: rtl/hp_nonce_feeder.sv
// ---------------------------------------------------------------------------
// hp_nonce_feeder
//
// Upstream stage of the hash pipe. Accepts one mining job (the last three
// header words of the second block-header chunk plus a nonce range) and then
// emits one fully padded 512-bit SHA-256 message block per clock. The nonce
// in word 3 is swept across the requested range.
//
// Block layout (word 0 at req_msg[MSGBITS-1 -: WORDBITS]):
//   w0..w2  job_tail words in order (merkle_tail, time, bits)
//   w3      nonce
//   w4      32'h8000_0000 (padding start bit)
//   w5..w14 zero
//   w15     32'h0000_0280 (640-bit message length)
//
// Ports:
//   clk              single clock, rising edge
//   rst              asynchronous, active-high reset
//   job_valid        job offered this cycle
//   job_ready        feeder can accept a job (IDLE only, decoded from state)
//   job_tail         {merkle_tail, time, bits}, merkle_tail in the top word
//   job_nonce_start  first nonce of the sweep
//   job_nonce_count  number of nonces; 0 means 2^32
//   stop             abort the sweep in progress (ignored in IDLE)
//   req_msg          message block to the hash pipe
//   req_valid        req_msg / req_nonce hold a new block this cycle
//   req_nonce        nonce embedded in req_msg
//   done             one-cycle pulse when a sweep finishes or is aborted
//   aborted          qualifies done: 1 when the sweep was ended by stop
// ---------------------------------------------------------------------------
module hp_nonce_feeder #(
    parameter int WORDBITS = 32,
    parameter int MSGWORDS = 16,
    parameter int MSGBITS  = MSGWORDS * WORDBITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [95:0]           job_tail,
    input  logic [31:0]           job_nonce_start,
    input  logic [31:0]           job_nonce_count,
    input  logic                  stop,
    output logic [MSGBITS-1:0]    req_msg,
    output logic                  req_valid,
    output logic [31:0]           req_nonce,
    output logic                  done,
    output logic                  aborted
);

    localparam logic [WORDBITS-1:0] PAD_WORD = WORDBITS'(32'h8000_0000);
    localparam logic [WORDBITS-1:0] LEN_WORD = WORDBITS'(32'h0000_0280);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Job registers
    logic [95:0]        tail_reg;
    logic [31:0]        nonce_reg;
    logic [31:0]        remaining_reg;
    // Set when the block just registered was the final one of the sweep.
    // Keeping this as a flag (rather than counting to -1) lets the
    // remaining counter stay 32 bits while still supporting 2^32 blocks.
    logic               last_reg;

    // Output registers
    logic [MSGBITS-1:0] req_msg_reg;
    logic               req_valid_reg;
    logic [31:0]        req_nonce_reg;
    logic               done_reg;
    logic               aborted_reg;

    // FSM decode
    logic               accept;
    logic               emit;
    logic               finish;
    logic               abort;

    logic [MSGBITS-1:0] msg_next;

    // -----------------------------------------------------------------------
    // Message block assembly from the job registers and current nonce
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < MSGWORDS; gi++) begin : g_word
            localparam int HI = MSGBITS - 1 - gi * WORDBITS;
            if (gi < 3) begin : g_tail
                assign msg_next[HI -: WORDBITS] = WORDBITS'(tail_reg[95 - gi * 32 -: 32]);
            end else if (gi == 3) begin : g_nonce
                assign msg_next[HI -: WORDBITS] = WORDBITS'(nonce_reg);
            end else if (gi == 4) begin : g_pad
                assign msg_next[HI -: WORDBITS] = PAD_WORD;
            end else if (gi == MSGWORDS - 1) begin : g_len
                assign msg_next[HI -: WORDBITS] = LEN_WORD;
            end else begin : g_zero
                assign msg_next[HI -: WORDBITS] = '0;
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state and control decode
    //
    // RUN priority: a sweep whose final block is currently on the output
    // completes normally even if stop is high in the same cycle; only then
    // is stop considered; otherwise another block is emitted.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        emit       = 1'b0;
        finish     = 1'b0;
        abort      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (job_valid) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_reg) begin
                    finish     = 1'b1;
                    state_next = ST_IDLE;
                end else if (stop) begin
                    abort      = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    emit       = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign job_ready = (state_reg == ST_IDLE);

    // -----------------------------------------------------------------------
    // Job registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tail_reg      <= '0;
            nonce_reg     <= '0;
            remaining_reg <= '0;
            last_reg      <= 1'b0;
        end else if (accept) begin
            tail_reg      <= job_tail;
            nonce_reg     <= job_nonce_start;
            // Count 0 wraps to all-ones, giving a full 2^32 sweep.
            remaining_reg <= job_nonce_count - 32'd1;
            last_reg      <= 1'b0;
        end else if (emit) begin
            nonce_reg     <= nonce_reg + 32'd1;
            remaining_reg <= remaining_reg - 32'd1;
            last_reg      <= (remaining_reg == 32'd0);
        end else if (finish) begin
            last_reg      <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Output registers. req_msg / req_nonce hold between blocks; consumers
    // qualify with req_valid.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_msg_reg   <= '0;
            req_nonce_reg <= '0;
            req_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
            aborted_reg   <= 1'b0;
        end else begin
            req_valid_reg <= emit;
            done_reg      <= finish | abort;
            aborted_reg   <= abort;
            if (emit) begin
                req_msg_reg   <= msg_next;
                req_nonce_reg <= nonce_reg;
            end
        end
    end

    assign req_msg   = req_msg_reg;
    assign req_valid = req_valid_reg;
    assign req_nonce = req_nonce_reg;
    assign done      = done_reg;
    assign aborted   = aborted_reg;

endmodule

// File: tb/tb_hp_nonce_feeder.sv
// ---------------------------------------------------------------------------
// tb_hp_nonce_feeder
//
// Stimulus pushes expected blocks / done pulses (with the cycle they must
// appear in) into a queue; a monitor on the falling edge pops and compares
// whenever the DUT shows req_valid or done.
// ---------------------------------------------------------------------------
module tb_hp_nonce_feeder;

    localparam int WORDBITS = 32;
    localparam int MSGWORDS = 16;
    localparam int MSGBITS  = MSGWORDS * WORDBITS;

    logic               clk;
    logic               rst;
    logic               job_valid;
    logic               job_ready;
    logic [95:0]        job_tail;
    logic [31:0]        job_nonce_start;
    logic [31:0]        job_nonce_count;
    logic               stop;
    logic [MSGBITS-1:0] req_msg;
    logic               req_valid;
    logic [31:0]        req_nonce;
    logic               done;
    logic               aborted;

    hp_nonce_feeder #(
        .WORDBITS(WORDBITS),
        .MSGWORDS(MSGWORDS)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .job_valid       (job_valid),
        .job_ready       (job_ready),
        .job_tail        (job_tail),
        .job_nonce_start (job_nonce_start),
        .job_nonce_count (job_nonce_count),
        .stop            (stop),
        .req_msg         (req_msg),
        .req_valid       (req_valid),
        .req_nonce       (req_nonce),
        .done            (done),
        .aborted         (aborted)
    );

    typedef struct {
        bit          is_done;
        bit          ab;
        logic [31:0] nonce;
        logic [95:0] tail;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------------------------------------------------------------
    // Monitor / scoreboard
    // ---------------------------------------------------------------------
    task automatic handle(input bit is_done);
        exp_t        e;
        logic [511:0] want;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s cyc=%0d nonce=%08h aborted=%0b required=nothing",
                     is_done ? "done" : "block", cyc, req_nonce, aborted);
            return;
        end
        e = exp_q.pop_front();
        if (e.is_done != is_done) begin
            errors++;
            $display("FAIL event_kind cyc=%0d got_done=%0b required_done=%0b", cyc, is_done, e.is_done);
            return;
        end
        checks++;
        if (cyc != e.cyc) begin
            errors++;
            $display("FAIL %s_cycle got=%0d required=%0d", is_done ? "done" : "block", cyc, e.cyc);
        end
        if (is_done) begin
            checks++;
            if (aborted !== e.ab) begin
                errors++;
                $display("FAIL aborted cyc=%0d got=%0b required=%0b", cyc, aborted, e.ab);
            end
            $display("done    cyc=%0d aborted=%0b", cyc, aborted);
        end else begin
            want = {e.tail, e.nonce, 32'h8000_0000, 320'd0, 32'h0000_0280};
            checks++;
            if (req_nonce !== e.nonce) begin
                errors++;
                $display("FAIL req_nonce cyc=%0d got=%08h required=%08h", cyc, req_nonce, e.nonce);
            end
            checks++;
            if (req_msg !== want) begin
                errors++;
                $display("FAIL req_msg cyc=%0d got=%0h required=%0h", cyc, req_msg, want);
            end
            $display("block   cyc=%0d nonce=%08h", cyc, req_nonce);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (req_valid === 1'b1) handle(1'b0);
            if (done === 1'b1)      handle(1'b1);
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------------
    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    // Present a job and hold it until accepted; e = cycle count after the
    // accepting edge (or -1 on timeout).
    task automatic offer_job(input logic [95:0] t, input logic [31:0] s,
                             input logic [31:0] c, output int e);
        job_valid       = 1'b1;
        job_tail        = t;
        job_nonce_start = s;
        job_nonce_count = c;
        e = -1;
        for (int i = 0; i < 300; i++) begin
            if (job_ready === 1'b1) begin
                e = cyc + 1;
                break;
            end
            @(negedge clk);
        end
        if (e < 0) begin
            checks++;
            errors++;
            $display("FAIL job_accept_timeout start=%08h", s);
            job_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 job_valid = 1'b0;
        $display("job     cyc=%0d start=%08h count=%0d", e, s, c);
    endtask

    task automatic push_blocks(input logic [95:0] t, input logic [31:0] s, input int n, input int e);
        exp_t x;
        for (int k = 0; k < n; k++) begin
            x.is_done = 1'b0;
            x.ab      = 1'b0;
            x.nonce   = s + 32'(k);
            x.tail    = t;
            x.cyc     = e + 1 + k;
            exp_q.push_back(x);
        end
    endtask

    task automatic push_done(input bit ab, input int c);
        exp_t x;
        x.is_done = 1'b1;
        x.ab      = ab;
        x.nonce   = '0;
        x.tail    = '0;
        x.cyc     = c;
        exp_q.push_back(x);
    endtask

    task automatic wait_cyc(input int target);
        do @(negedge clk); while (cyc < target);
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    // Directed tests
    // ---------------------------------------------------------------------
    localparam logic [95:0] T1 = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    localparam logic [95:0] T2 = {32'hDEAD_BEEF, 32'h5F5E_1000, 32'h1703_A30C};
    localparam logic [95:0] T3 = {32'hA5A5_5A5A, 32'h0000_0001, 32'hFFFF_0000};

    initial begin
        int e;
        int e2;
        rst             = 1'b1;
        job_valid       = 1'b0;
        job_tail        = '0;
        job_nonce_start = '0;
        job_nonce_count = '0;
        stop            = 1'b0;

        // Reset state
        #2;
        check_val("rst_req_valid", 32'(req_valid), 32'd0);
        check_val("rst_done",      32'(done),      32'd0);
        check_val("rst_aborted",   32'(aborted),   32'd0);
        check_val("rst_job_ready", 32'(job_ready), 32'd1);
        check_val("rst_req_nonce", req_nonce,      32'd0);
        checks++;
        if (req_msg !== '0) begin
            errors++;
            $display("FAIL rst_req_msg got=%0h required=0", req_msg);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic sweep: nonces 5,6,7
        offer_job(T1, 32'd5, 32'd3, e);
        push_blocks(T1, 32'd5, 3, e);
        push_done(1'b0, e + 4);
        wait_cyc(e + 6);

        // Nonce wrap
        offer_job(T2, 32'hFFFF_FFFE, 32'd4, e);
        push_blocks(T2, 32'hFFFF_FFFE, 4, e);
        push_done(1'b0, e + 5);
        wait_cyc(e + 7);

        // Single block
        offer_job(T3, 32'h1234_5678, 32'd1, e);
        push_blocks(T3, 32'h1234_5678, 1, e);
        push_done(1'b0, e + 2);
        wait_cyc(e + 4);

        // Stop in IDLE is ignored (monitor flags any stray done)
        stop = 1'b1;
        repeat (3) @(negedge clk);
        stop = 1'b0;
        check_val("idle_stop_ready", 32'(job_ready), 32'd1);

        // Count 0: full sweep, still running after 1000 blocks, then stopped
        offer_job(T1, 32'h0000_1000, 32'd0, e);
        push_blocks(T1, 32'h0000_1000, 1000, e);
        push_done(1'b1, e + 1001);
        wait_cyc(e + 500);
        check_val("full_sweep_ready", 32'(job_ready), 32'd0);
        check_val("full_sweep_valid", 32'(req_valid), 32'd1);
        wait_cyc(e + 1000);
        check_val("full_sweep_nonce", req_nonce, 32'h0000_13E7);
        pulse_stop();
        wait_cyc(e + 1003);

        // Stop after the 10th block
        offer_job(T2, 32'd0, 32'd100, e);
        push_blocks(T2, 32'd0, 10, e);
        push_done(1'b1, e + 11);
        wait_cyc(e + 10);
        pulse_stop();
        wait_cyc(e + 13);

        // Stop coincident with the final block: normal completion
        offer_job(T3, 32'd40, 32'd4, e);
        push_blocks(T3, 32'd40, 4, e);
        push_done(1'b0, e + 5);
        wait_cyc(e + 4);
        pulse_stop();
        wait_cyc(e + 7);

        // Back-to-back: second job held during the first sweep
        offer_job(T1, 32'd100, 32'd3, e);
        push_blocks(T1, 32'd100, 3, e);
        push_done(1'b0, e + 4);
        offer_job(T2, 32'd200, 32'd2, e2);
        check_val("b2b_accept_cycle", 32'(e2), 32'(e + 5));
        push_blocks(T2, 32'd200, 2, e2);
        push_done(1'b0, e2 + 3);
        wait_cyc(e2 + 5);

        // Asynchronous reset mid-sweep
        offer_job(T3, 32'd50, 32'd20, e);
        push_blocks(T3, 32'd50, 5, e);
        wait_cyc(e + 5);
        #2 rst = 1'b1;
        #1;
        check_val("midrst_req_valid", 32'(req_valid), 32'd0);
        check_val("midrst_done",      32'(done),      32'd0);
        check_val("midrst_job_ready", 32'(job_ready), 32'd1);
        check_val("midrst_req_nonce", req_nonce,      32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        offer_job(T1, 32'd7, 32'd2, e);
        push_blocks(T1, 32'd7, 2, e);
        push_done(1'b0, e + 3);
        wait_cyc(e + 6);

        check_val("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d pending=%0d", cyc, exp_q.size());
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/hp_nonce_feeder.md
# hp_nonce_feeder

Upstream stage of the hash pipe: accepts one mining job (the last three header words of a block-header second chunk plus a nonce range) and emits one fully padded 512-bit message block per clock, sweeping the nonce. Its req_msg output drives the pipe's msg_in directly, one block per cycle, and req_nonce tags each block for downstream result matching. It is pure sequential control: a job handshake, a two-state FSM, a nonce counter and a remaining-count counter.

## Interface
- WORDBITS, 32, bits per message word
- MSGWORDS, 16, words per message block
- MSGBITS, MSGWORDS*WORDBITS (512), message block width
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- job_valid  in  1  job offered this cycle
- job_ready  out  1  feeder can accept a job (high only in IDLE)
- job_tail  in  96  {merkle_tail, time, bits}, merkle_tail in [95:64]
- job_nonce_start  in  32  first nonce of the sweep
- job_nonce_count  in  32  number of nonces; 0 means 2^32 (full sweep)
- stop  in  1  abort current sweep
- req_msg  out  MSGBITS  message block to hash pipe
- req_valid  out  1  req_msg/req_nonce hold a new block this cycle
- req_nonce  out  32  nonce embedded in req_msg
- done  out  1  one-cycle pulse, sweep finished or aborted
- aborted  out  1  qualifies done: 1 = ended by stop

## Operation
- Block layout, word 0 at req_msg[511:480], word 15 at [31:0]: w0..w2 = job_tail words in order; w3 = nonce; w4 = 32'h8000_0000; w5..w14 = 0; w15 = 32'h0000_0280 (640-bit message length).
- Job registers (tail, nonce, remaining) load only on job_valid & job_ready; remaining loads job_nonce_count - 1 (mod 2^32), so count 0 yields 2^32 blocks.
- FSM states IDLE, RUN:
  - IDLE: job_ready = 1; on accept -> RUN.
  - RUN: job_ready = 0; each cycle register req_msg with current nonce, req_valid = 1, nonce += 1 (wraps 32'hFFFF_FFFF -> 0), remaining -= 1.
  - RUN, block emitted with remaining == 0 -> IDLE, done = 1, aborted = 0 next cycle.
  - RUN, stop sampled high -> IDLE, done = 1, aborted = 1 next cycle; no further blocks. Blocks already emitted remain valid.
  - stop and final block in the same cycle: normal completion (aborted = 0).
  - stop in IDLE: ignored.
- All outputs registered except job_ready (decoded from state).
- req_msg holds its last value when req_valid = 0; downstream must qualify with req_valid.
- Reset (any time, including mid-sweep): state IDLE, req_valid 0, req_msg 0, req_nonce 0, done 0, aborted 0, job_ready 1; in-flight sweep is discarded without a done pulse.

## Timing
- Job accepted at edge E: first block (nonce_start) valid in the cycle after E; block k valid k cycles after that.
- count N: req_valid high for exactly N consecutive cycles, no bubbles.
- done pulses for the single cycle after the last req_valid cycle; job_ready is high in that same cycle, so a new job is accepted there; a new sweep's first block therefore follows the previous sweep's last block with a gap of exactly 2 cycles.
- stop sampled at edge S: last block is the one registered at S-1's edge (valid during the cycle in which stop is sampled); req_valid low from S, done/aborted high for one cycle after S.
- Throughput: one 512-bit block per clock while in RUN.

## Test plan
- Reset then job tail={32'h1111_1111,32'h2222_2222,32'h3333_3333}, start 5, count 3 -> blocks with nonces 5,6,7 on 3 consecutive cycles, w4=8000_0000, w15=0000_0280, done=1 aborted=0 one cycle later.
- start 32'hFFFF_FFFE, count 4 -> nonces FFFF_FFFE, FFFF_FFFF, 0, 1.
- count 1 -> single req_valid cycle, done the following cycle; count 0 -> remaining loads FFFF_FFFF, still RUN after 1000 cycles, nonce advanced by 1000.
- start 0, count 100, stop after 10th block cycle -> exactly 10 blocks (0..9), done=1 aborted=1; stop coincident with final block of count 4 -> 4 blocks, aborted=0.
- Back-to-back: second job held with job_valid high during first sweep -> accepted in done cycle, first new block 2 cycles after last old block.
- rst asserted mid-sweep (asynchronously, between edges) -> req_valid drops immediately, no done, job_ready=1; new job after release runs normally.
